// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock into a 2*WIDTH accumulator.
// Define BOOTH_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier digits are all zero.
module booth_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               cancel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);

  localparam int N     = (WIDTH + 2) / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam int YW    = WIDTH + 3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic nz;
    logic two;
    logic neg;
  } digit_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic signed [PW-1:0] x_q, x_d;
  logic signed [PW-1:0] acc_q, acc_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic [YW-1:0]        y_q, y_d;
  logic                 ext;
  digit_t               dig;
  logic signed [PW-1:0] acc_sum;
  logic                 exit_now;

  function automatic digit_t booth_decode(input logic [2:0] win);
    digit_t d;
    d.nz  = (win != 3'b000) && (win != 3'b111);
    d.two = (win == 3'b011) || (win == 3'b100);
    d.neg = win[2] && d.nz;
    return d;
  endfunction

  // Returns the magnitude term, already inverted for negative digits; the +1 comes in as carry.
  function automatic logic signed [PW-1:0] booth_addend(input digit_t d,
                                                        input logic signed [PW-1:0] x);
    logic signed [PW-1:0] mag;
    mag = d.two ? (x <<< 1) : x;
    if (!d.nz) begin
      mag = '0;
    end
    return d.neg ? ~mag : mag;
  endfunction

  // x_q and y_q shift by one digit per step, so the live window is always y_q[2:0].
  assign ext     = in_signed & in_b[WIDTH-1];
  assign dig     = booth_decode(y_q[2:0]);
  assign acc_sum = acc_q + booth_addend(dig, x_q) + {{(PW-1){1'b0}}, dig.neg};

`ifdef BOOTH_MUL_EARLY_EXIT_EN
  // y_q is shifted with sign fill, so y_q[WIDTH+1:0] uniform means every remaining digit is zero.
  assign exit_now = (&y_q[WIDTH+1:0]) | ~(|y_q[WIDTH+1:0]);
`else
  assign exit_now = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    if (cancel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_d     = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
            y_d     = {ext, ext, in_b, 1'b0};
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          if (exit_now) begin
            prod_d  = acc_q;
            state_d = DONE;
          end else begin
            acc_d = acc_sum;
            x_d   = x_q <<< 2;
            y_d   = {y_q[YW-1], y_q[YW-1], y_q[YW-1:2]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
              prod_d  = acc_sum;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  // Operand shift registers are pure data and are always reloaded on accept.
  always_ff @(posedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_prod  = prod_q;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Testbench for booth_mul_iter: vector table, handshake corner sequences and a randomised scoreboard run.
module tb_booth_mul_iter;

  localparam int W = 32;
  localparam int N = (W + 2) / 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic           in_signed;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           cancel;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic           busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2*W-1:0] exp_q[$];
  logic           hold_v = 1'b0;
  logic [2*W-1:0] hold_p = '0;

  booth_mul_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .cancel    (cancel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

`ifdef BOOTH_MUL_EARLY_EXIT_EN
  function automatic int lat_model(input logic [31:0] b, input logic s);
    logic [W+2:0] y;
    logic         e;
    logic         uni;
    e = s & b[W-1];
    y = {e, e, b, 1'b0};
    for (int i = 0; i < N; i++) begin
      uni = 1'b1;
      for (int j = 2 * i; j <= W + 1; j++) begin
        if (y[j] != y[W+1]) uni = 1'b0;
      end
      if (uni) return i + 1;
    end
    return N;
  endfunction
`endif

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string name, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    if (!out_valid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: out_valid not seen within %0d cycles", name, cyc);
    end
  endtask

  // Scoreboard: push at accept, drop on cancel/reset, compare on transfer; also checks DONE holds.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold_v <= 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_prod", out_prod, hold_p);
      end
      if (in_valid && in_ready && !cancel) begin
        exp_q.push_back(ref_mul(in_a, in_b, in_signed));
      end
      if (cancel && busy) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL sb_spurious: got product 0x%h, want no result", out_prod);
        end else begin
          check("sb_prod", out_prod, exp_q.pop_front());
        end
      end
      hold_v <= out_valid && !out_ready && !cancel;
      hold_p <= out_prod;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[10];
  int   lat;
  int   exp_lat;

  initial begin
    vecs[0] = '{32'hFFFF_FFFD, 32'd7,        1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'd5,         32'd3,        1'b0, 64'd15};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1};
    vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000};
    vecs[6] = '{32'd0,         32'd12345,    1'b1, 64'd0};
    vecs[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001};
    vecs[8] = '{32'hFFFF_FFFD, 32'd7,        1'b0, 64'h0000_0006_FFFF_FFEB};
    vecs[9] = '{32'd5,         32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    cancel    = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_prod", out_prod, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();

    // Vector table: latency from accept edge and product
    for (int i = 0; i < 10; i++) begin
      in_a      = vecs[i].a;
      in_b      = vecs[i].b;
      in_signed = vecs[i].s;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
      wait_out_valid($sformatf("vec%0d_wait", i), lat);
      exp_lat = N;
`ifdef BOOTH_MUL_EARLY_EXIT_EN
      exp_lat = lat_model(vecs[i].b, vecs[i].s);
`endif
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
      check($sformatf("vec%0d_prod", i), out_prod, vecs[i].p);
      tick();
      check($sformatf("vec%0d_ready_after", i), 64'(in_ready), 64'd1);
    end

    // Backpressure in DONE
    in_a = 32'hFFFF_FFFD; in_b = 32'd7; in_signed = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out_valid("bp_wait", lat);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_prod", out_prod, 64'hFFFF_FFFF_FFFF_FFEB);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Cancel mid-CALC with the next request already waiting
    in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_signed = 1'b1;
    in_valid = 1'b1;
    tick();
    in_a = 32'hDEAD_BEEF; in_b = 32'h0000_1234; in_signed = 1'b0;
    repeat (6) tick();
    check("cxl_busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cxl_out_valid", 64'(out_valid), 64'd0);
    check("cxl_in_ready", 64'(in_ready), 64'd1);
    check("cxl_busy", 64'(busy), 64'd0);
    tick();
    in_valid = 1'b0;
    check("cxl_reaccept_busy", 64'(busy), 64'd1);
    wait_out_valid("cxl_wait", lat);
    exp_lat = N;
`ifdef BOOTH_MUL_EARLY_EXIT_EN
    exp_lat = lat_model(32'h0000_1234, 1'b0);
`endif
    check("cxl_latency", 64'(lat), 64'(exp_lat));
    check("cxl_prod", out_prod, ref_mul(32'hDEAD_BEEF, 32'h0000_1234, 1'b0));
    tick();

    // Reset while holding a result in DONE
    in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_signed = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out_valid("rstdone_wait", lat);
    check("rstdone_prod_before", out_prod, 64'hFFFF_FFFE_0000_0001);
    reset = 1'b1;
    tick();
    check("rstdone_out_prod", out_prod, 64'd0);
    check("rstdone_out_valid", 64'(out_valid), 64'd0);
    check("rstdone_in_ready", 64'(in_ready), 64'd1);
    check("rstdone_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();

    // Randomised traffic against the scoreboard
    for (int c = 0; c < 8000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cancel    = ($urandom_range(0, 49) == 0);
      in_signed = 1'($urandom_range(0, 1));
      in_a      = pick();
      in_b      = pick();
      tick();
    end
    cancel    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (25) tick();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
